// File: rtl/microsequencer_ctrl_pkg.sv
// Shared types and constants for the microcode sequencer: FSM states, microword layout, ctrl bit map.
// No logic and no latency; backpressure is not applicable to this package.
package microsequencer_ctrl_pkg;

  localparam int DEF_OP_W   = 4;
  localparam int DEF_FLAG_W = 2;
  localparam int DEF_CW_W   = 13;
  localparam int DEF_PH_W   = 2;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

  // Microword layout: {halt, last, cw}
  localparam int LAST_BIT = DEF_CW_W;
  localparam int HALT_BIT = DEF_CW_W + 1;
  localparam int UW_W     = DEF_CW_W + 2;

  localparam int CB_PC_INC  = 12;
  localparam int CB_PC_LD   = 11;
  localparam int CB_MAR_LD  = 10;
  localparam int CB_MEM_RD  = 9;
  localparam int CB_MEM_WR  = 8;
  localparam int CB_ACC_LD  = 7;
  localparam int CB_ACC_OE  = 6;
  localparam int CB_ALU_ADD = 5;
  localparam int CB_ALU_SUB = 4;
  localparam int CB_IR_LD   = 3;
  localparam int CB_B_LD    = 2;
  localparam int CB_OUT_LD  = 1;
  localparam int CB_HLT_ACK = 0;

  localparam logic [DEF_CW_W-1:0] DEF_FETCH_CW =
    (13'd1 << CB_PC_INC) | (13'd1 << CB_IR_LD);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  function automatic logic is_active(input state_t s);
    return (s == ST_FETCH) || (s == ST_WAIT) || (s == ST_EXEC);
  endfunction

endpackage

// File: rtl/microsequencer_ctrl_rom.sv
// Combinational microcode ROM indexed by {op, flags, phase}; returns {halt, last, cw}.
// Zero latency, no backpressure; unmapped entries decode to a one-step NOP.
module microcode_rom #(
  parameter int OP_W   = 4,
  parameter int FLAG_W = 2,
  parameter int CW_W   = 13,
  parameter int PH_W   = 2
) (
  input  logic [OP_W-1:0]   op,
  input  logic [FLAG_W-1:0] flags,
  input  logic [PH_W-1:0]   phase,
  output logic [CW_W+1:0]   uword
);

  logic [OP_W+FLAG_W+PH_W-1:0] key;

  assign key = {op, flags, phase};

  // Table is laid out for the default 4/2/2 key; flags field is {C, Z}.
  always_comb begin
    uword = {1'b0, 1'b1, {CW_W{1'b0}}};
    casez (key)
      8'b0010_??_00: uword = {2'b01, 13'b0001001000010};
      8'b0011_??_00: uword = {2'b01, 13'b1001001100000};
      8'b1000_?1_00: uword = {2'b01, 13'b0100000001000};
      8'b1000_?0_00: uword = {2'b01, 13'b1000000001000};
      8'b1001_?1_00: uword = {2'b01, 13'b1000000001000};
      8'b1001_?0_00: uword = {2'b01, 13'b0100000001000};
      8'b1101_??_00: uword = {2'b11, 13'b0000000001001};
      8'b1111_??_00: uword = {2'b00, 13'b0011100000010};
      8'b1111_??_01: uword = {2'b01, 13'b1011100100000};
      default:       uword = {1'b0, 1'b1, {CW_W{1'b0}}};
    endcase
  end

endmodule

// File: rtl/microsequencer_ctrl.sv
// Registered microcode sequencer: IDLE -> FETCH -> WAIT -> EXEC steps (-> HALT); every output is a flop.
// Outputs describe the step entered on the same edge; stall withholds that step's word and re-issues it once released.
module microsequencer_ctrl
  import microsequencer_ctrl_pkg::*;
#(
  parameter int                OP_W     = DEF_OP_W,
  parameter int                FLAG_W   = DEF_FLAG_W,
  parameter int                CW_W     = DEF_CW_W,
  parameter int                PH_W     = DEF_PH_W,
  parameter logic [CW_W-1:0]   FETCH_CW = DEF_FETCH_CW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [OP_W-1:0]   opcode,
  input  logic [FLAG_W-1:0] flags,
  input  logic              instr_valid,
  input  logic              stall,
  output logic [CW_W-1:0]   ctrl,
  output logic [PH_W-1:0]   phase,
  output logic              busy,
  output logic              instr_done,
  output logic              halted
);

  localparam logic [PH_W-1:0] PH_MAX = '1;

  state_t            state, state_nx;
  logic [PH_W-1:0]   phase_nx;
  logic [OP_W-1:0]   op_q, op_nx;
  logic              halt_q, last_q, held_q;
  logic              halt_nx, last_nx, held_nx, done_nx;
  logic [CW_W-1:0]   ctrl_nx;
  logic [CW_W+1:0]   uword;
  logic              frozen;

  // The ROM is addressed with the step about to be entered, so its word
  // lands in ctrl on the same edge as the state/phase that it belongs to.
  microcode_rom #(
    .OP_W   (OP_W),
    .FLAG_W (FLAG_W),
    .CW_W   (CW_W),
    .PH_W   (PH_W)
  ) u_rom (
    .op    (op_nx),
    .flags (flags),
    .phase (phase_nx),
    .uword (uword)
  );

  assign frozen = stall && is_active(state);

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    op_nx    = op_q;
    halt_nx  = 1'b0;
    last_nx  = 1'b0;
    done_nx  = 1'b0;
    ctrl_nx  = '0;
    held_nx  = 1'b0;

    // A withheld step is re-entered as-is instead of advancing past it.
    if (!held_q) begin
      case (state)
        ST_IDLE:  state_nx = ST_FETCH;
        ST_FETCH: state_nx = ST_WAIT;
        ST_WAIT: begin
          if (instr_valid) begin
            state_nx = ST_EXEC;
            op_nx    = opcode;
            phase_nx = '0;
          end
        end
        ST_EXEC: begin
          if (halt_q) begin
            state_nx = ST_HALT;
            phase_nx = '0;
          end else if (last_q) begin
            state_nx = ST_FETCH;
            phase_nx = '0;
          end else begin
            phase_nx = phase + 1'b1;
          end
        end
        ST_HALT:  state_nx = ST_HALT;
        default:  state_nx = ST_IDLE;
      endcase
    end

    if (state_nx == ST_EXEC) begin
      halt_nx = uword[HALT_BIT];
      last_nx = uword[LAST_BIT] || (phase_nx == PH_MAX);
      ctrl_nx = uword[CW_W-1:0];
      done_nx = last_nx && !halt_nx;
    end else if (state_nx == ST_FETCH) begin
      ctrl_nx = FETCH_CW;
    end

    if (frozen) begin
      ctrl_nx = '0;
      done_nx = 1'b0;
      held_nx = (state_nx != ST_HALT);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      phase      <= '0;
      op_q       <= '0;
      halt_q     <= 1'b0;
      last_q     <= 1'b0;
      held_q     <= 1'b0;
      ctrl       <= '0;
      busy       <= 1'b0;
      instr_done <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_nx;
      phase      <= phase_nx;
      op_q       <= op_nx;
      halt_q     <= halt_nx;
      last_q     <= last_nx;
      held_q     <= held_nx;
      ctrl       <= ctrl_nx;
      busy       <= is_active(state_nx);
      instr_done <= done_nx;
      halted     <= (state_nx == ST_HALT);
    end
  end

endmodule

// File: tb/tb_microsequencer_ctrl.sv
// Bench for microsequencer_ctrl: directed vector table, hand-written reset/halt sequences, then random stimulus vs a reference model.
module tb_microsequencer_ctrl;

  localparam logic [12:0] FCW = 13'b1000000001000;
  localparam logic [12:0] C2  = 13'b0001001000010;
  localparam logic [12:0] C3  = 13'b1001001100000;
  localparam logic [12:0] CA  = 13'b0100000001000;
  localparam logic [12:0] CB  = 13'b1000000001000;
  localparam logic [12:0] CH  = 13'b0000000001001;
  localparam logic [12:0] F0  = 13'b0011100000010;
  localparam logic [12:0] F1  = 13'b1011100100000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  opcode = '0;
  logic [1:0]  flags = '0;
  logic        instr_valid = 1'b0;
  logic        stall = 1'b0;
  logic [12:0] ctrl;
  logic [1:0]  phase;
  logic        busy, instr_done, halted;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  microsequencer_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .opcode      (opcode),
    .flags       (flags),
    .instr_valid (instr_valid),
    .stall       (stall),
    .ctrl        (ctrl),
    .phase       (phase),
    .busy        (busy),
    .instr_done  (instr_done),
    .halted      (halted)
  );

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  fl;
    logic        iv;
    logic        st;
    logic [12:0] ctrl;
    logic [1:0]  ph;
    logic        busy;
    logic        done;
    logic        hlt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [3:0] op, input logic [1:0] fl, input logic iv,
                             input logic st, input logic [12:0] c, input logic [1:0] p,
                             input logic b, input logic d, input logic h);
    vec_t r;
    r.op = op; r.fl = fl; r.iv = iv; r.st = st;
    r.ctrl = c; r.ph = p; r.busy = b; r.done = d; r.hlt = h;
    return r;
  endfunction

  task automatic check(input string name, input logic [12:0] c, input logic [1:0] p,
                       input logic b, input logic d, input logic h);
    checks++;
    if ({ctrl, phase, busy, instr_done, halted} === {c, p, b, d, h}) passed++;
    else $display("FAIL %s: got ctrl=%b phase=%0d busy=%b done=%b halted=%b, want ctrl=%b phase=%0d busy=%b done=%b halted=%b",
                  name, ctrl, phase, busy, instr_done, halted, c, p, b, d, h);
  endtask

  task automatic apply(input vec_t x, input string name);
    opcode = x.op; flags = x.fl; instr_valid = x.iv; stall = x.st;
    @(posedge clk);
    #1;
    check(name, x.ctrl, x.ph, x.busy, x.done, x.hlt);
  endtask

  // Reference model: one issue slot per clock edge; a stalled edge parks the
  // slot with its word withheld and the next clean edge emits it.
  typedef enum int {W_IDLE, W_FETCH, W_WAIT, W_EXEC, W_HALT} where_e;
  where_e      m_where;
  logic [3:0]  m_op;
  int          m_ph;
  bit          m_last, m_hlt, m_withheld;
  logic [12:0] e_ctrl;
  logic [1:0]  e_phase;
  logic        e_busy, e_done, e_halt;

  function automatic void rom_ref(input logic [3:0] op, input logic [1:0] fl, input int ph,
                                  output logic [12:0] cw, output bit last, output bit hlt);
    bit z;
    z = fl[0];
    cw = '0; last = 1'b1; hlt = 1'b0;
    if (ph == 0) begin
      case (op)
        4'b0010: cw = C2;
        4'b0011: cw = C3;
        4'b1000: cw = z ? CA : CB;
        4'b1001: cw = z ? CB : CA;
        4'b1101: begin cw = CH; hlt = 1'b1; end
        4'b1111: begin cw = F0; last = 1'b0; end
        default: ;
      endcase
    end else if (ph == 1 && op == 4'b1111) begin
      cw = F1;
    end
  endfunction

  task automatic model_reset();
    m_where = W_IDLE; m_op = '0; m_ph = 0;
    m_last = 1'b0; m_hlt = 1'b0; m_withheld = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] op, input logic [1:0] fl, input logic iv, input logic st);
    bit          frz;
    logic [12:0] cw;
    frz = st && (m_where == W_FETCH || m_where == W_WAIT || m_where == W_EXEC);
    if (!m_withheld) begin
      case (m_where)
        W_IDLE:  m_where = W_FETCH;
        W_FETCH: m_where = W_WAIT;
        W_WAIT:  if (iv) begin m_where = W_EXEC; m_op = op; m_ph = 0; end
        W_EXEC: begin
          if (m_hlt) m_where = W_HALT;
          else if (m_last) begin m_where = W_FETCH; m_ph = 0; end
          else m_ph = m_ph + 1;
        end
        default: ;
      endcase
    end
    e_ctrl = '0; e_done = 1'b0;
    if (m_where == W_EXEC) begin
      rom_ref(m_op, fl, m_ph, cw, m_last, m_hlt);
      m_last = m_last || (m_ph == 3);
      e_ctrl = cw;
      e_done = m_last && !m_hlt;
    end else if (m_where == W_FETCH) begin
      e_ctrl = FCW;
    end
    if (frz) begin e_ctrl = '0; e_done = 1'b0; end
    m_withheld = frz && (m_where != W_HALT);
    e_phase = (m_where == W_EXEC) ? 2'(m_ph) : 2'd0;
    e_busy  = (m_where == W_FETCH || m_where == W_WAIT || m_where == W_EXEC);
    e_halt  = (m_where == W_HALT);
  endtask

  logic [3:0] ops [10] = '{4'h2, 4'h3, 4'h8, 4'h9, 4'hF, 4'hF, 4'hF, 4'h5, 4'hC, 4'hD};

  initial begin
    // reset release, fetch, park in WAIT
    tbl.push_back(v(4'h0, 2'b00, 0, 0, FCW, 0, 1, 0, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, '0,  0, 1, 0, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, '0,  0, 1, 0, 0));
    // single-step ops and flag-conditioned ops
    tbl.push_back(v(4'h2, 2'b00, 1, 0, C2,  0, 1, 1, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, FCW, 0, 1, 0, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, '0,  0, 1, 0, 0));
    tbl.push_back(v(4'h8, 2'b01, 1, 0, CA,  0, 1, 1, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, FCW, 0, 1, 0, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, '0,  0, 1, 0, 0));
    tbl.push_back(v(4'h8, 2'b00, 1, 0, CB,  0, 1, 1, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, FCW, 0, 1, 0, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, '0,  0, 1, 0, 0));
    tbl.push_back(v(4'h9, 2'b10, 1, 0, CA,  0, 1, 1, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, FCW, 0, 1, 0, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, '0,  0, 1, 0, 0));
    tbl.push_back(v(4'h9, 2'b01, 1, 0, CB,  0, 1, 1, 0));
    // instr_valid while leaving EXEC and FETCH is ignored
    tbl.push_back(v(4'h2, 2'b00, 1, 0, FCW, 0, 1, 0, 0));
    tbl.push_back(v(4'h2, 2'b00, 1, 0, '0,  0, 1, 0, 0));
    tbl.push_back(v(4'h3, 2'b00, 1, 0, C3,  0, 1, 1, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, FCW, 0, 1, 0, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, '0,  0, 1, 0, 0));
    // unmapped opcode: one-step NOP
    tbl.push_back(v(4'h5, 2'b11, 1, 0, '0,  0, 1, 1, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, FCW, 0, 1, 0, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, '0,  0, 1, 0, 0));
    // two-step op with a 3-cycle stall on phase 1
    tbl.push_back(v(4'hF, 2'b00, 1, 0, F0,  0, 1, 0, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 1, '0,  1, 1, 0, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 1, '0,  1, 1, 0, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 1, '0,  1, 1, 0, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, F1,  1, 1, 1, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, FCW, 0, 1, 0, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, '0,  0, 1, 0, 0));
    // stall on the edge into FETCH: fetch word issued exactly once after release
    tbl.push_back(v(4'h2, 2'b00, 1, 0, C2,  0, 1, 1, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 1, '0,  0, 1, 0, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, FCW, 0, 1, 0, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, '0,  0, 1, 0, 0));
    // stall while consuming an opcode: latched op survives an opcode change
    tbl.push_back(v(4'h3, 2'b00, 1, 1, '0,  0, 1, 0, 0));
    tbl.push_back(v(4'h2, 2'b00, 0, 0, C3,  0, 1, 1, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, FCW, 0, 1, 0, 0));
    tbl.push_back(v(4'h0, 2'b00, 0, 0, '0,  0, 1, 0, 0));
    // halt
    tbl.push_back(v(4'hD, 2'b00, 1, 0, CH,  0, 1, 0, 0));
    tbl.push_back(v(4'h0, 2'b00, 1, 0, '0,  0, 0, 0, 1));

    #2 reset_n = 1'b0;
    @(posedge clk);
    #1 check("reset_state", '0, 0, 0, 0, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      opcode = 4'($urandom); instr_valid = 1'b1; stall = 1'($urandom);
      @(posedge clk);
      #1 check("halt_hold", '0, 0, 0, 0, 1);
    end

    // asynchronous reset in the middle of a two-step instruction
    #2 reset_n = 1'b0;
    #1 check("reset_from_halt", '0, 0, 0, 0, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    apply(v(4'h0, 2'b00, 0, 0, FCW, 0, 1, 0, 0), "post_reset_fetch");
    apply(v(4'h0, 2'b00, 0, 0, '0,  0, 1, 0, 0), "post_reset_wait");
    apply(v(4'hF, 2'b00, 1, 0, F0,  0, 1, 0, 0), "exec_before_abort");
    #3 reset_n = 1'b0;
    #1 check("abort_mid_exec", '0, 0, 0, 0, 0);
    @(posedge clk);
    #1 check("abort_held", '0, 0, 0, 0, 0);
    reset_n = 1'b1;
    apply(v(4'h0, 2'b00, 1, 0, FCW, 0, 1, 0, 0), "resume_fetch");
    apply(v(4'h0, 2'b00, 0, 0, '0,  0, 1, 0, 0), "resume_wait");

    // randomized run against the reference model
    #2 reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ((m_where == W_HALT && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0) begin
        #2 reset_n = 1'b0;
        #1 check("rnd_reset", '0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
      end else begin
        opcode      = ops[$urandom_range(0, 9)];
        flags       = 2'($urandom);
        instr_valid = ($urandom_range(0, 2) == 0);
        stall       = ($urandom_range(0, 3) == 0);
        model_edge(opcode, flags, instr_valid, stall);
        @(posedge clk);
        #1 check($sformatf("rnd%0d", i), e_ctrl, e_phase, e_busy, e_done, e_halt);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
